// File: rtl/square_wave_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : square_wave_meter_if
//  Description : Measurement bus for square_wave_meter. The master side
//                supplies the enable, the waveform samples and the slice
//                threshold. The slave side (the meter) returns the measured
//                period, the high time, the prescaler estimate and the
//                valid, locked and timeout status flags.
//  Signals     : ena            measure enable
//                data_in        waveform sample [WIDTH]
//                threshold      slice level [WIDTH]
//                period         cycles between the last two rising edges [CNT_W]
//                high_time      cycles from a rising edge to the next falling edge [CNT_W]
//                prescaler_est  equivalent generator prescaler [16]
//                valid          1-cycle pulse when new results are published
//                locked         measurement lock flag
//                timeout        1-cycle loss-of-signal pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface square_wave_meter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 24
);
  logic             ena;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] threshold;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [15:0]      prescaler_est;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    output ena, data_in, threshold,
    input  period, high_time, prescaler_est, valid, locked, timeout
  );

  modport slave (
    input  ena, data_in, threshold,
    output period, high_time, prescaler_est, valid, locked, timeout
  );
endinterface
`default_nettype wire

// File: rtl/square_wave_meter.sv
`default_nettype none
// ============================================================================
//  Module      : square_wave_meter
//  Description : Receive-side companion to the square-wave generator. It
//                slices a sampled waveform against a threshold, then measures
//                the period and the high time in clk cycles. It also reports
//                the equivalent generator prescaler, a lock flag and a
//                loss-of-signal timeout.
//  Ports       : clk    system clock, all logic on the rising edge
//                rst_n  synchronous reset, active low
//                bus    square_wave_meter_if.slave
//                       ena, data_in and threshold are inputs.
//                       period, high_time, prescaler_est, valid, locked and
//                       timeout are outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module square_wave_meter #(
  parameter int          WIDTH   = 16,
  parameter int          CNT_W   = 24,
  parameter int unsigned TIMEOUT = 32'h000F_FFFF
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  square_wave_meter_if.slave   bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ARM     = 2'd1;
  localparam logic [1:0] c_SYNC    = 2'd2;
  localparam logic [1:0] c_MEASURE = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lvl_q;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic [15:0]      r_prescaler_est;
  logic             r_valid;
  logic             r_locked;
  logic             r_timeout;

  logic [WIDTH-1:0] w_sample;
  logic [WIDTH-1:0] w_thr;
  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic             w_to_hit;
  logic [CNT_W-1:0] w_half_m1;
  logic [15:0]      w_est;

  assign w_sample = bus.data_in;
  assign w_thr    = bus.threshold;
  assign w_level  = (w_sample >= w_thr);
  assign w_rise   = !r_lvl_q &&  w_level;
  assign w_fall   =  r_lvl_q && !w_level;
  assign w_to_hit = (r_cnt == CNT_W'(TIMEOUT));

  // The count at a rising edge is the new period. A generator that toggles
  // every N+1 samples gives period 2(N+1), so N = (period>>1)-1.
  assign w_half_m1 = (r_cnt >> 1) - CNT_W'(1);

  always_comb begin
    w_est = 16'd0;
    if (r_cnt < CNT_W'(2)) begin
      w_est = 16'd0;
    end else if (w_half_m1 > CNT_W'(16'hFFFF)) begin
      w_est = 16'hFFFF;
    end else begin
      w_est = w_half_m1[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= c_IDLE;
      r_cnt           <= '0;
      r_lvl_q         <= 1'b0;
      r_period        <= '0;
      r_high_time     <= '0;
      r_prescaler_est <= 16'd0;
      r_valid         <= 1'b0;
      r_locked        <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (!bus.ena) begin
        // Measured values are held so that the last reading stays visible.
        r_state  <= c_IDLE;
        r_cnt    <= '0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE: begin
            r_cnt   <= '0;
            r_state <= c_ARM;
          end
          c_ARM: begin
            // Prime the level history so the first enabled sample cannot
            // appear as an edge.
            r_lvl_q <= w_level;
            r_cnt   <= '0;
            r_state <= c_SYNC;
          end
          c_SYNC: begin
            r_lvl_q <= w_level;
            if (w_rise) begin
              r_cnt   <= CNT_W'(1);
              r_state <= c_MEASURE;
            end else if (w_to_hit) begin
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          c_MEASURE: begin
            r_lvl_q <= w_level;
            if (w_fall) begin
              r_high_time <= r_cnt;
            end
            // A rise in the same cycle as the timeout count takes priority.
            if (w_rise) begin
              r_period        <= r_cnt;
              r_prescaler_est <= w_est;
              r_cnt           <= CNT_W'(1);
              r_valid         <= 1'b1;
              r_locked        <= 1'b1;
            end else if (w_to_hit) begin
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_cnt     <= '0;
              r_state   <= c_SYNC;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period        = r_period;
  assign bus.high_time     = r_high_time;
  assign bus.prescaler_est = r_prescaler_est;
  assign bus.valid         = r_valid;
  assign bus.locked        = r_locked;
  assign bus.timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_square_wave_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_square_wave_meter
//  Description : Self-checking bench for square_wave_meter. The stimulus
//                tasks push the expected publications (cycle, period,
//                high time and estimate) into a queue. A monitor pops an
//                entry and compares it on every valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_square_wave_meter;

  localparam int TO = 100;

  typedef struct {
    int          cyc;
    logic [23:0] per;
    logic [23:0] hi;
    logic [15:0] est;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  square_wave_meter_if #(.WIDTH(16), .CNT_W(24)) bus ();

  square_wave_meter #(.WIDTH(16), .CNT_W(24), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;
  int   tout_cnt   = 0;
  exp_t sb[$];
  exp_t m_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor. Outputs are read on the falling edge, so at that
  // point cyc is the number of the posedge that produced them.
  always @(negedge clk) begin
    if (bus.timeout === 1'b1) tout_cnt++;
    if (bus.valid === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        m_e = sb.pop_front();
        if (cyc !== m_e.cyc) begin
          mismatched++;
          $display("FAIL valid_cycle: got %0d, expected %0d", cyc, m_e.cyc);
        end
        compared++;
        if (bus.period !== m_e.per) begin
          mismatched++;
          $display("FAIL period: got %0d, expected %0d", bus.period, m_e.per);
        end
        compared++;
        if (bus.high_time !== m_e.hi) begin
          mismatched++;
          $display("FAIL high_time: got %0d, expected %0d", bus.high_time, m_e.hi);
        end
        compared++;
        if (bus.prescaler_est !== m_e.est) begin
          mismatched++;
          $display("FAIL prescaler_est: got %0d, expected %0d", bus.prescaler_est, m_e.est);
        end
      end
    end
  end

  // Drive one sample. The sample is taken at the next posedge.
  task automatic drive(input logic [15:0] d, input logic e);
    @(negedge clk);
    bus.data_in = d;
    bus.ena     = e;
  endtask

  // Expect a publication from the sample that was just driven.
  task automatic push(input int h);
    exp_t e;
    e.cyc = cyc + 1;
    e.per = 24'(2 * h);
    e.hi  = 24'(h);
    e.est = 16'(h - 1);
    sb.push_back(e);
  endtask

  // Square wave with equal high and low halves. Each period starts with a
  // rising sample. The first rise after re-arming is only a sync edge.
  task automatic wave(input logic [15:0] lo, input logic [15:0] hi, input int half,
                      input int nper, input bit skip_first);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < half; i++) begin
        drive(hi, 1'b1);
        if (i == 0 && !(skip_first && p == 0)) push(half);
      end
      for (int i = 0; i < half; i++) drive(lo, 1'b1);
    end
  endtask

  task automatic restart(input logic [15:0] lo);
    drive(lo, 1'b0);
    drive(lo, 1'b0);
    for (int i = 0; i < 3; i++) drive(lo, 1'b1);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) drive((i % 2) ? 16'hFFFF : 16'h0000, 1'b1);
    compared++;
    if (bus.period !== 24'd0) begin mismatched++; $display("FAIL rst_period: got %0d, expected 0", bus.period); end
    compared++;
    if (bus.high_time !== 24'd0) begin mismatched++; $display("FAIL rst_high_time: got %0d, expected 0", bus.high_time); end
    compared++;
    if (bus.prescaler_est !== 16'd0) begin mismatched++; $display("FAIL rst_est: got %0d, expected 0", bus.prescaler_est); end
    compared++;
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b, expected 0", bus.valid); end
    compared++;
    if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL rst_locked: got %b, expected 0", bus.locked); end
    compared++;
    if (bus.timeout !== 1'b0) begin mismatched++; $display("FAIL rst_timeout: got %b, expected 0", bus.timeout); end
    drive(16'h0000, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_period10;
    restart(16'h0000);
    wave(16'h0000, 16'hFFFF, 5, 4, 1'b1);
    compared++;
    if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL p10_locked: got %b, expected 1", bus.locked); end
  endtask

  task automatic test_fast;
    restart(16'h0000);
    wave(16'h0000, 16'hFFFF, 1, 6, 1'b1);
    compared++;
    if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL fast_locked: got %b, expected 1", bus.locked); end
  endtask

  task automatic test_timeout;
    int rise_cyc;
    bit seen;
    restart(16'h0000);
    wave(16'h0000, 16'hFFFF, 5, 3, 1'b1);
    drive(16'hFFFF, 1'b1);
    push(5);
    rise_cyc = cyc + 1;
    seen = 1'b0;
    for (int k = 0; k < 130 && !seen; k++) begin
      drive(16'hFFFF, 1'b1);
      if (cyc == rise_cyc + TO - 1) begin
        compared++;
        if (bus.timeout !== 1'b0 || bus.locked !== 1'b1) begin
          mismatched++;
          $display("FAIL to_early: timeout=%b locked=%b, expected timeout=0 locked=1", bus.timeout, bus.locked);
        end
      end
      if (bus.timeout === 1'b1) begin
        seen = 1'b1;
        compared++;
        if (cyc !== rise_cyc + TO) begin mismatched++; $display("FAIL to_cycle: got %0d, expected %0d", cyc, rise_cyc + TO); end
        compared++;
        if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL to_locked: got %b, expected 0", bus.locked); end
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL to_missing: got no timeout, expected timeout at cycle %0d", rise_cyc + TO);
    end
    drive(16'hFFFF, 1'b1);
    compared++;
    if (bus.timeout !== 1'b0) begin mismatched++; $display("FAIL to_pulse_width: got %b, expected 0", bus.timeout); end
    for (int i = 0; i < 5; i++) drive(16'h0000, 1'b1);
    wave(16'h0000, 16'hFFFF, 5, 2, 1'b1);
    compared++;
    if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL to_relock: got %b, expected 1", bus.locked); end
  endtask

  task automatic test_ena_drop;
    int q;
    bit seen;
    restart(16'h0000);
    wave(16'h0000, 16'hFFFF, 5, 2, 1'b1);
    drive(16'h0000, 1'b0);
    drive(16'hFFFF, 1'b0);
    compared++;
    if (bus.locked !== 1'b0) begin mismatched++; $display("FAIL ena_locked: got %b, expected 0", bus.locked); end
    compared++;
    if (bus.period !== 24'd10) begin mismatched++; $display("FAIL ena_period_hold: got %0d, expected 10", bus.period); end
    for (int i = 0; i < 6; i++) drive((i % 2) ? 16'hFFFF : 16'h0000, 1'b0);
    drive(16'hFFFF, 1'b1);
    q = cyc + 1;
    seen = 1'b0;
    for (int k = 0; k < 130 && !seen; k++) begin
      drive(16'hFFFF, 1'b1);
      if (bus.timeout === 1'b1) begin
        seen = 1'b1;
        compared++;
        if (cyc !== q + TO + 2) begin mismatched++; $display("FAIL ena_to_cycle: got %0d, expected %0d", cyc, q + TO + 2); end
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL ena_to_missing: got no timeout, expected timeout at cycle %0d", q + TO + 2);
    end
    compared++;
    if (bus.period !== 24'd10) begin mismatched++; $display("FAIL ena_period_after: got %0d, expected 10", bus.period); end
    drive(16'hFFFF, 1'b0);
    drive(16'hFFFF, 1'b0);
  endtask

  task automatic test_threshold;
    bus.threshold = 16'h8000;
    restart(16'h7FFF);
    wave(16'h7FFF, 16'h8000, 3, 4, 1'b1);
    compared++;
    if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL thr_locked: got %b, expected 1", bus.locked); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ena       = 1'b1;
    bus.data_in   = 16'h0000;
    bus.threshold = 16'h8000;
    test_reset();
    test_period10();
    test_fast();
    test_timeout();
    test_ena_drop();
    test_threshold();
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    compared++;
    if (sb.size() != 0) begin mismatched++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    compared++;
    if (tout_cnt !== 2) begin mismatched++; $display("FAIL timeout_count: got %0d, expected 2", tout_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
